// File: rtl/pc_sequencer_pkg.sv
// Shared uPC definitions: FSM states, fault codes and default widths
// common to the sequencer and the return-address stack.
package uPC_pkg;

  localparam int unsigned AW_DEF    = 8;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned DEPTH_W   = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_HALTED   = 2'd2,
    ST_FAULT    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE = 2'd0,
    FLT_OVF  = 2'd1,
    FLT_UNF  = 2'd2
  } fault_e;

endpackage

// File: rtl/pc_sequencer_depth_counter.sv
// Return-stack occupancy counter, falling-edge clocked like the stack.
// It saturates at 0 and DEPTH; the sequencer also gates inc/dec so that a
// refused push/pop never reaches the stack.
module depth_counter #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 5
) (
  input  logic          nclk_i,
  input  logic          nreset_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [CW-1:0] count_q, count_d;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Next occupancy: increment has priority, both ends saturate.
  always_comb begin
    count_d = count_q;
    if (inc_i && !full_o) begin
      count_d = count_q + CW'(1);
    end else if (dec_i && !empty_o) begin
      count_d = count_q - CW'(1);
    end
  end

  // Occupancy register.
  always_ff @(negedge nclk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// uPC program-counter sequencer: next-PC selection, return-stack control
// (push/pop/return address), depth tracking and overflow/underflow fault.
module pc_sequencer
  import uPC_pkg::*;
#(
  parameter int unsigned    AW       = AW_DEF,
  parameter int unsigned    DEPTH    = DEPTH_DEF,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic                nclk,
  input  logic                nreset,
  input  logic                enable,
  input  logic                halt,
  input  logic                resume,
  input  logic                jump,
  input  logic                cjump,
  input  logic                flag,
  input  logic                call,
  input  logic                ret,
  input  logic [AW-1:0]       target,
  input  logic [AW-1:0]       stack_top,
  output logic [AW-1:0]       pc,
  output logic                push,
  output logic                pop,
  output logic [AW-1:0]       ret_addr,
  output logic                busy,
  output logic [DEPTH_W-1:0]  depth,
  output logic                fault,
  output logic [1:0]          fault_code
);

  state_e        state_q, state_d;
  fault_e        code_q, code_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc_inc;
  logic          full, empty;

  assign pc_inc     = pc_q + AW'(1);
  assign ret_addr   = pc_inc;
  assign pc         = pc_q;
  assign busy       = (state_q == ST_RET_WAIT);
  assign fault      = (state_q == ST_FAULT);
  assign fault_code = code_q;

  depth_counter #(
    .DEPTH (DEPTH),
    .CW    (DEPTH_W)
  ) u_depth (
    .nclk_i   (nclk),
    .nreset_i (nreset),
    .inc_i    (push),
    .dec_i    (pop),
    .count_o  (depth),
    .full_o   (full),
    .empty_o  (empty)
  );

  // Next-state, next-PC and stack strobes. Strobes are qualified with nreset
  // so the stack sees no push/pop while the sequencer is held in reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    code_d  = code_q;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (enable) begin
          if (halt) begin
            state_d = ST_HALTED;
          end else if (ret) begin
            if (!empty) begin
              pop     = nreset;
              state_d = ST_RET_WAIT;
            end else begin
              state_d = ST_FAULT;
              code_d  = FLT_UNF;
            end
          end else if (call) begin
            if (!full) begin
              push = nreset;
              pc_d = target;
            end else begin
              state_d = ST_FAULT;
              code_d  = FLT_OVF;
            end
          end else if (jump) begin
            pc_d = target;
          end else if (cjump) begin
            pc_d = flag ? target : pc_inc;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      ST_RET_WAIT: begin
        pc_d    = stack_top;
        state_d = ST_RUN;
      end
      ST_HALTED: begin
        if (resume) begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, PC and fault-code registers, updated on the stack's clock edge.
  always_ff @(negedge nclk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      code_q  <= FLT_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      code_q  <= code_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a queue-based return-stack model predicts every
// output each cycle; directed steps add literal expectations.
module tb_pc_sequencer;

  logic       nclk = 1'b1;
  logic       nreset = 1'b0;
  logic       enable = 1'b0, halt = 1'b0, resume = 1'b0, jump = 1'b0;
  logic       cjump = 1'b0, flag = 1'b0, call = 1'b0, ret = 1'b0;
  logic [7:0] target = 8'h00;
  logic [7:0] stack_top;
  logic [7:0] pc, ret_addr;
  logic       push, pop, busy, fault;
  logic [4:0] depth;
  logic [1:0] fault_code;

  int n_vec = 0;
  int n_err = 0;

  always #5 nclk = ~nclk;

  pc_sequencer #(.AW(8), .DEPTH(16), .RESET_PC(8'h00)) dut (
    .nclk       (nclk),
    .nreset     (nreset),
    .enable     (enable),
    .halt       (halt),
    .resume     (resume),
    .jump       (jump),
    .cjump      (cjump),
    .flag       (flag),
    .call       (call),
    .ret        (ret),
    .target     (target),
    .stack_top  (stack_top),
    .pc         (pc),
    .push       (push),
    .pop        (pop),
    .ret_addr   (ret_addr),
    .busy       (busy),
    .depth      (depth),
    .fault      (fault),
    .fault_code (fault_code)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_RUN, M_WAIT, M_HALT, M_FAULT} mode_t;
  mode_t      m_mode = M_RUN;
  int         m_pc = 0;
  int         m_code = 0;
  logic [7:0] ras[$];
  logic [7:0] m_retval = 8'hA5;

  // The return stack's data_out: the value popped by the last RETURN.
  assign stack_top = m_retval;

  always @(negedge nclk or negedge nreset) begin
    if (!nreset) begin
      m_mode = M_RUN;
      m_pc   = 0;
      m_code = 0;
      ras.delete();
    end else begin
      case (m_mode)
        M_RUN: if (enable) begin
          if (halt) m_mode = M_HALT;
          else if (ret) begin
            if (ras.size() > 0) begin
              m_retval = ras.pop_back();
              m_mode   = M_WAIT;
            end else begin
              m_mode = M_FAULT;
              m_code = 2;
            end
          end else if (call) begin
            if (ras.size() < 16) begin
              ras.push_back(8'((m_pc + 1) % 256));
              m_pc = target;
            end else begin
              m_mode = M_FAULT;
              m_code = 1;
            end
          end else if (jump) m_pc = target;
          else if (cjump) m_pc = flag ? int'(target) : (m_pc + 1) % 256;
          else m_pc = (m_pc + 1) % 256;
        end
        M_WAIT: begin
          m_pc   = m_retval;
          m_mode = M_RUN;
        end
        M_HALT: if (resume) m_mode = M_RUN;
        default: ;
      endcase
    end
  end

  // ---------------- compare process ----------------
  logic e_push, e_pop, e_op;
  always @(posedge nclk) begin
    e_op   = nreset && (m_mode == M_RUN) && enable && !halt;
    e_push = e_op && !ret && call && (ras.size() < 16);
    e_pop  = e_op && ret && (ras.size() > 0);
    chk("pc",         pc,         m_pc);
    chk("depth",      depth,      ras.size());
    chk("push",       push,       e_push);
    chk("pop",        pop,        e_pop);
    chk("push_pop",   push & pop, 0);
    chk("busy",       busy,       nreset && (m_mode == M_WAIT));
    chk("fault",      fault,      m_mode == M_FAULT);
    chk("fault_code", fault_code, m_code);
    chk("ret_addr",   ret_addr,   (m_pc + 1) % 256);
  end

  // ---------------- directed stimulus ----------------
  logic mid_push, mid_pop, mid_busy;
  logic [7:0] mid_ra;

  // Drive one instruction slot; entered and left just after a falling edge.
  task automatic step(input logic e, h, rs, j, cj, f, c, r, input logic [7:0] t);
    enable = e; halt = h; resume = rs; jump = j;
    cjump = cj; flag = f; call = c; ret = r; target = t;
    @(posedge nclk); #1;
    mid_push = push; mid_pop = pop; mid_busy = busy; mid_ra = ret_addr;
    @(negedge nclk); #1;
  endtask

  task automatic nop(); step(1,0,0,0,0,0,0,0,8'h00); endtask

  // Pulse reset between clock edges and check the immediate effect.
  task automatic mid_reset(input string tag);
    #2 nreset = 1'b0;
    #1;
    chk({tag, "_pc"},    pc,         8'h00);
    chk({tag, "_fault"}, fault,      1'b0);
    chk({tag, "_code"},  fault_code, 2'd0);
    chk({tag, "_depth"}, depth,      5'd0);
    chk({tag, "_busy"},  busy,       1'b0);
    nreset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge nclk);
    #1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_push", push, 1'b0);
    chk("rst_fault", fault, 1'b0);
    nreset = 1'b1;

    // Plain increments from reset.
    nop(); nop(); nop();
    chk("inc3_pc", pc, 8'h03);
    chk("inc3_push", mid_push, 1'b0);
    nop(); nop();
    chk("inc5_pc", pc, 8'h05);

    // CALL then RETURN; inputs in RET_WAIT must be ignored.
    step(1,0,0,0,0,0,1,0,8'h40);
    chk("call_push", mid_push, 1'b1);
    chk("call_ra", mid_ra, 8'h06);
    chk("call_pc", pc, 8'h40);
    chk("call_depth", depth, 5'd1);
    step(1,0,0,0,0,0,0,1,8'h00);
    chk("ret_pop", mid_pop, 1'b1);
    chk("ret_busy", busy, 1'b1);
    chk("ret_depth", depth, 5'd0);
    step(1,0,0,0,0,0,1,0,8'h77);
    chk("rw_busy", mid_busy, 1'b1);
    chk("rw_push", mid_push, 1'b0);
    chk("rw_pc", pc, 8'h06);
    chk("rw_done", busy, 1'b0);

    // Conditional jump and wrap-around.
    step(1,0,0,1,0,0,0,0,8'h10);
    step(1,0,0,0,1,0,0,0,8'h20);
    chk("cj0_pc", pc, 8'h11);
    step(1,0,0,0,1,1,0,0,8'h20);
    chk("cj1_pc", pc, 8'h20);
    step(1,0,0,1,0,0,0,0,8'hFF);
    nop();
    chk("wrap_ra", mid_ra, 8'h00);
    chk("wrap_pc", pc, 8'h00);

    // Priority: ret beats call and jump.
    step(1,0,0,0,0,0,1,0,8'h30);
    step(1,0,0,1,0,0,1,1,8'h50);
    chk("pri_pop", mid_pop, 1'b1);
    chk("pri_push", mid_push, 1'b0);
    chk("pri_pc", pc, 8'h30);
    nop();
    chk("pri_ret_pc", pc, 8'h01);

    // HALT, hold, resume, and disabled cycle.
    step(1,0,0,1,0,0,0,0,8'h08);
    step(1,1,0,0,0,0,0,0,8'h00);
    for (int i = 0; i < 5; i++) step(1,1,0,1,0,0,1,0,8'h99);
    chk("halt_pc", pc, 8'h08);
    step(0,0,1,0,0,0,0,0,8'h00);
    chk("resume_pc", pc, 8'h08);
    nop();
    chk("resume_step_pc", pc, 8'h09);
    step(0,0,0,0,0,0,0,0,8'h00);
    chk("dis_pc", pc, 8'h09);

    // Reset while waiting on a return.
    step(1,0,0,0,0,0,1,0,8'h60);
    step(1,0,0,0,0,0,0,1,8'h00);
    chk("rw2_busy", busy, 1'b1);
    mid_reset("rst_rw");
    nop();
    chk("rst_rw_run", pc, 8'h01);

    // Underflow.
    step(1,0,0,1,0,0,0,0,8'h33);
    step(1,0,0,0,0,0,0,1,8'h00);
    chk("unf_pop", mid_pop, 1'b0);
    chk("unf_fault", fault, 1'b1);
    chk("unf_code", fault_code, 2'd2);
    nop(); nop();
    chk("unf_pc", pc, 8'h33);
    mid_reset("rst_unf");

    // Overflow: 16 nested calls fill the stack, the 17th faults.
    for (int i = 0; i < 16; i++) step(1,0,0,0,0,0,1,0,8'(i * 8 + 3));
    chk("full_depth", depth, 5'd16);
    chk("full_pc", pc, 8'h7B);
    step(1,0,0,0,0,0,1,0,8'hEE);
    chk("ovf_push", mid_push, 1'b0);
    chk("ovf_fault", fault, 1'b1);
    chk("ovf_code", fault_code, 2'd1);
    chk("ovf_pc", pc, 8'h7B);
    chk("ovf_depth", depth, 5'd16);
    nop();
    mid_reset("rst_ovf");
    nop(); nop();
    chk("post_pc", pc, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer for the uPC; sits directly upstream of the 16-entry return-address stack.
- Each step it computes the next PC: increment, jump, conditional jump, CALL or RETURN.
- It drives the stack's count_up/count_down/data_in and consumes its data_out on RETURN.
- It tracks stack depth, blocks overflow/underflow, and latches a fault.

Parameters:
AW, 8, PC / address width (matches stack data width)
DEPTH, 16, return-stack entries
RESET_PC, 0, PC value after reset

Ports:
nclk  input  1  clock; all state updates on falling edge (same edge as the stack)
nreset  input  1  reset, asynchronous, active-low
enable  input  1  advance one instruction this cycle
halt  input  1  decoded HALT instruction
resume  input  1  leave HALTED
jump  input  1  unconditional jump to target
cjump  input  1  jump to target if flag=1
flag  input  1  condition flag from ALU
call  input  1  CALL target
ret  input  1  RETURN
target  input  AW  jump/call destination
stack_top  input  AW  stack data_out (asynchronous)
pc  output  AW  current program counter
push  output  1  to stack count_up
pop  output  1  to stack count_down
ret_addr  output  AW  to stack data_in; always pc+1 (mod 2^AW)
busy  output  1  high in RET_WAIT; fetch must stall
depth  output  5  current stack occupancy, 0..DEPTH
fault  output  1  high in FAULT
fault_code  output  2  0 none, 1 overflow, 2 underflow

Behaviour:
- Reset (async, nreset=0): pc=RESET_PC; state=RUN; depth=0; fault=0; fault_code=0.
  - push=pop=busy=0 while in reset.
  - Reset mid-RET_WAIT or in FAULT returns to RUN immediately.
- States: RUN, RET_WAIT, HALTED, FAULT.
- Operations act only when state=RUN and enable=1. Otherwise pc holds and push=pop=0.
- Priority when several are asserted: halt > ret > call > jump > cjump > increment.
- RUN operations (all results on next falling edge):
  - halt: pc holds; state→HALTED.
  - ret, depth>0: pop=1 (combinational this cycle); depth-1; pc holds; state→RET_WAIT.
  - ret, depth=0: pop=0; state→FAULT; fault_code=2.
  - call, depth<DEPTH: push=1 (combinational); stack latches ret_addr=pc+1; depth+1; pc=target.
  - call, depth=DEPTH: push=0; state→FAULT; fault_code=1; pc holds.
  - jump: pc=target.
  - cjump: pc = flag ? target : pc+1.
  - none of the above: pc=pc+1; wraps 2^AW-1→0.
- RET_WAIT:
  - busy=1.
  - Stack pointer has just decremented, so stack_top now shows the pushed return address.
  - Next edge: pc=stack_top; state→RUN.
  - All inputs are ignored in RET_WAIT.
  - Net RETURN latency: 2 edges.
- HALTED: pc holds. resume=1 → RUN on next edge; halt is ignored here.
- FAULT: pc, depth and fault_code frozen; fault=1; exit only via nreset.
- push and pop are never both 1.
- push and pop are combinational from state, enable, decode and depth; they must be stable before the falling edge.
- ret_addr is combinational pc+1, truncated to AW.

Decomposition:
- Shared package uPC_pkg holds:
  - state encoding constants ST_RUN=0, ST_RET_WAIT=1, ST_HALTED=2, ST_FAULT=3;
  - fault codes FLT_NONE, FLT_OVF, FLT_UNF;
  - AW and DEPTH defaults, shared with the stack.
- One sub-module, depth_counter: up/down occupancy counter with full/empty flags; pc_sequencer gates inc/dec with full/empty.
- Next-PC mux and FSM stay in pc_sequencer.

Test Plan:
- Reset then enable=1 for 3 cycles, no ops → pc 0,1,2,3; push=pop=0; depth=0.
- pc=0x05, call target=0x40 → push=1 with ret_addr=0x06; next pc=0x40, depth=1.
  - Then ret → pop=1, busy=1 one cycle; with stack_top=0x06, pc=0x06, depth=0, state RUN.
- 16 nested calls then a 17th call → push=0 on 17th; fault=1, fault_code=1; pc frozen.
  - Assert nreset low mid-cycle → pc=0, fault=0 immediately.
- ret at depth=0 → pop=0, fault=1, fault_code=2.
- cjump target=0x20 with flag=0 at pc=0x10 → pc=0x11; flag=1 → pc=0x20.
  - pc=0xFF increment → 0x00.
- call+jump+ret asserted together at depth=1 → ret wins (pop=1, push=0).
  - halt at pc=0x08 → pc holds for 5 cycles; resume → pc=0x09 after next enabled step.
